// File: rtl/occupancy_light_ctrl.sv
// occupancy_light_ctrl: per-zone debounced movement/dark gate with hold-timer FSM.
// Define OCCUPANCY_MANUAL_OVERRIDE_EN to add a synchronised per-zone force_on input.
module occupancy_light_ctrl #(
  parameter int NUM_ZONES       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 1000,
  localparam int CW = $clog2(NUM_ZONES + 1),
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1,
  localparam int TW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_ZONES-1:0] movement,
  input  logic                 dark,
`ifdef OCCUPANCY_MANUAL_OVERRIDE_EN
  input  logic [NUM_ZONES-1:0] force_on,
`endif
  output logic [NUM_ZONES-1:0] auto_light,
  output logic [NUM_ZONES-1:0] timeout,
  output logic [CW-1:0]        occupied_count,
  output logic                 any_light
);

  localparam int NB = NUM_ZONES + 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HLOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON   = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [NB-1:0] raw, s1, s2, db;
  logic [DW-1:0] dcnt [NB];
  logic [NUM_ZONES-1:0] mov_db;
  logic dark_db;

  state_t state [NUM_ZONES];
  state_t nxt [NUM_ZONES];
  logic [TW-1:0] timer [NUM_ZONES];
  logic [TW-1:0] timer_nxt [NUM_ZONES];

  logic [NUM_ZONES-1:0] light_q;
  logic [CW-1:0] cnt_nxt;

  assign raw = {dark, movement};
  assign mov_db = db[NUM_ZONES-1:0];
  assign dark_db = db[NUM_ZONES];

  // Bit NUM_ZONES of every vector here is the shared dark sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DLAST) begin
          db[i]   <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef OCCUPANCY_MANUAL_OVERRIDE_EN
  logic [NUM_ZONES-1:0] f1, frc, frc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1    <= '0;
      frc   <= '0;
      frc_q <= '0;
    end else begin
      f1    <= force_on;
      frc   <= f1;
      frc_q <= frc;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        state[i] <= OFF;
        timer[i] <= '0;
      end
    end else begin
      state <= nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      nxt[i]       = state[i];
      timer_nxt[i] = timer[i];
      unique case (state[i])
        OFF: begin
          if (mov_db[i] && dark_db) nxt[i] = ON;
        end
        ON: begin
          if (!mov_db[i]) begin
            nxt[i]       = HOLD;
            timer_nxt[i] = HLOAD;
          end
        end
        HOLD: begin
          // Retrigger beats expiry, so no pulse when both coincide.
          if (mov_db[i]) begin
            nxt[i] = ON;
          end else if (timer[i] == '0) begin
            nxt[i] = OFF;
          end else begin
            timer_nxt[i] = timer[i] - 1'b1;
          end
        end
        default: nxt[i] = OFF;
      endcase
`ifdef OCCUPANCY_MANUAL_OVERRIDE_EN
      if (frc[i]) begin
        nxt[i]       = ON;
        timer_nxt[i] = timer[i];
      end else if (frc_q[i] && state[i] == ON) begin
        nxt[i]       = HOLD;
        timer_nxt[i] = HLOAD;
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      timeout[i] = (state[i] == HOLD) && (nxt[i] == OFF);
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      cnt_nxt = cnt_nxt + CW'(light_q[i]);
    end
  end

  // Light follows the next state so it lands on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_q        <= '0;
      occupied_count <= '0;
      any_light      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        light_q[i] <= (nxt[i] != OFF);
      end
      occupied_count <= cnt_nxt;
      any_light      <= |light_q;
    end
  end

  assign auto_light = light_q;

endmodule

// File: tb/tb_occupancy_light_ctrl.sv
// tb_occupancy_light_ctrl: scoreboard bench, expectations queued per cycle
// when stimulus is driven and compared on the falling edge.
module tb_occupancy_light_ctrl;

  localparam int NZ = 4;
  localparam int DEB = 4;
  localparam int HOLD = 16;
  localparam int CW = $clog2(NZ + 1);

  localparam logic [1:0] SIG_LIGHT = 2'd0;
  localparam logic [1:0] SIG_TMO   = 2'd1;
  localparam logic [1:0] SIG_CNT   = 2'd2;
  localparam logic [1:0] SIG_ANY   = 2'd3;

  typedef struct packed {
    int          cyc;
    logic [95:0] tag;
    logic [1:0]  sig;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NZ-1:0] movement = '0;
  logic dark = 1'b0;
`ifdef OCCUPANCY_MANUAL_OVERRIDE_EN
  logic [NZ-1:0] force_on = '0;
`endif
  logic [NZ-1:0] auto_light;
  logic [NZ-1:0] timeout;
  logic [CW-1:0] occupied_count;
  logic any_light;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];

  occupancy_light_ctrl #(
    .NUM_ZONES(NZ),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .movement(movement),
    .dark(dark),
`ifdef OCCUPANCY_MANUAL_OVERRIDE_EN
    .force_on(force_on),
`endif
    .auto_light(auto_light),
    .timeout(timeout),
    .occupied_count(occupied_count),
    .any_light(any_light)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input logic [95:0] tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %0s at cycle %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input logic [1:0] s);
    case (s)
      SIG_LIGHT: return 32'(auto_light);
      SIG_TMO:   return 32'(timeout);
      SIG_CNT:   return 32'(occupied_count);
      default:   return 32'(any_light);
    endcase
  endfunction

  task automatic expect_at(input int c, input logic [95:0] tag,
                           input logic [1:0] s, input logic [31:0] m,
                           input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.sig = s;
    e.mask = m;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_span(input int from, input int to,
                             input logic [95:0] tag, input logic [1:0] s,
                             input logic [31:0] m, input logic [31:0] v);
    for (int k = from; k <= to; k++) expect_at(k, tag, s, m, v);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc)
        check(sb[i].tag, observe(sb[i].sig) & sb[i].mask, sb[i].val);
      else if (sb[i].cyc < cyc)
        check("sb_late", 32'(cyc), 32'(sb[i].cyc));
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c;

    tick(3);
    check("rst_light", 32'(auto_light), 0);
    check("rst_tmo", 32'(timeout), 0);
    check("rst_cnt", 32'(occupied_count), 0);
    check("rst_any", 32'(any_light), 0);

    rst_n = 1'b1;
    c = cyc;
    expect_span(c + 1, c + 50, "idle_light", SIG_LIGHT, 'hF, 0);
    expect_span(c + 1, c + 50, "idle_tmo", SIG_TMO, 'hF, 0);
    expect_span(c + 1, c + 50, "idle_cnt", SIG_CNT, 'h7, 0);
    expect_span(c + 1, c + 50, "idle_any", SIG_ANY, 'h1, 0);
    tick(50);

    dark = 1'b1;
    tick(10);
    movement[0] = 1'b1;
    c = cyc;
    expect_at(c + 6, "z0_early", SIG_LIGHT, 'hF, 0);
    expect_at(c + 7, "z0_on", SIG_LIGHT, 'hF, 'b0001);
    expect_at(c + 7, "z0_cnt0", SIG_CNT, 'h7, 0);
    expect_at(c + 8, "z0_cnt1", SIG_CNT, 'h7, 1);
    expect_at(c + 8, "z0_any", SIG_ANY, 'h1, 1);
    tick(20);

    movement[0] = 1'b0;
    c = cyc;
    expect_span(c + 1, c + 22, "z0_hold", SIG_LIGHT, 'h1, 1);
    expect_span(c + 1, c + 21, "z0_notmo", SIG_TMO, 'hF, 0);
    expect_at(c + 22, "z0_tmo", SIG_TMO, 'hF, 'b0001);
    expect_at(c + 23, "z0_tmo_end", SIG_TMO, 'hF, 0);
    expect_at(c + 23, "z0_off", SIG_LIGHT, 'hF, 0);
    expect_at(c + 24, "z0_cnt_off", SIG_CNT, 'h7, 0);
    expect_at(c + 24, "z0_any_off", SIG_ANY, 'h1, 0);
    tick(30);

    movement[0] = 1'b1;
    tick(20);
    movement[0] = 1'b0;
    c = cyc;
    expect_span(c + 1, c + 60, "rt_light", SIG_LIGHT, 'h1, 1);
    expect_span(c + 1, c + 60, "rt_tmo", SIG_TMO, 'h1, 0);
    tick(15);
    movement[0] = 1'b1;
    tick(20);
    movement[0] = 1'b0;
    c = cyc;
    // Debounced movement lands exactly on the timer==0 cycle.
    expect_span(c + 1, c + 40, "race_light", SIG_LIGHT, 'h1, 1);
    expect_span(c + 1, c + 40, "race_tmo", SIG_TMO, 'h1, 0);
    tick(16);
    movement[0] = 1'b1;
    tick(30);
    movement[0] = 1'b0;
    c = cyc;
    expect_at(c + 22, "z0_tmo2", SIG_TMO, 'hF, 'b0001);
    expect_at(c + 23, "z0_off2", SIG_LIGHT, 'h1, 0);
    tick(30);

    dark = 1'b0;
    tick(10);
    movement[1] = 1'b1;
    c = cyc;
    expect_span(c + 1, c + 30, "bright_off", SIG_LIGHT, 'h2, 0);
    tick(30);
    dark = 1'b1;
    c = cyc;
    expect_at(c + 6, "dark_early", SIG_LIGHT, 'h2, 0);
    expect_at(c + 7, "dark_on", SIG_LIGHT, 'h2, 'h2);
    tick(15);
    dark = 1'b0;
    c = cyc;
    expect_span(c + 1, c + 30, "bright_keep", SIG_LIGHT, 'h2, 'h2);
    tick(30);
    movement[1] = 1'b0;
    c = cyc;
    expect_at(c + 22, "z1_tmo", SIG_TMO, 'hF, 'b0010);
    expect_at(c + 23, "z1_off", SIG_LIGHT, 'h2, 0);
    tick(30);

    dark = 1'b1;
    tick(10);
    c = cyc;
    expect_span(c + 1, c + 110, "glitch", SIG_LIGHT, 'h4, 0);
    for (int k = 0; k < 17; k++) begin
      movement[2] = 1'b1;
      tick(3);
      movement[2] = 1'b0;
      tick(3);
    end
    tick(10);

    movement = 4'hF;
    c = cyc;
    expect_at(c + 6, "all_early", SIG_LIGHT, 'hF, 0);
    expect_at(c + 7, "all_on", SIG_LIGHT, 'hF, 'hF);
    expect_at(c + 8, "all_cnt", SIG_CNT, 'h7, 4);
    expect_at(c + 8, "all_any", SIG_ANY, 'h1, 1);
    tick(15);
    movement = 4'h0;
    c = cyc;
    expect_at(c + 12, "mid_hold", SIG_LIGHT, 'hF, 'hF);
    expect_at(c + 12, "mid_cnt", SIG_CNT, 'h7, 4);
    tick(12);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_light", 32'(auto_light), 0);
    check("arst_tmo", 32'(timeout), 0);
    check("arst_cnt", 32'(occupied_count), 0);
    check("arst_any", 32'(any_light), 0);
    tick(3);
    rst_n = 1'b1;
    c = cyc;
    expect_span(c + 1, c + 40, "post_tmo", SIG_TMO, 'hF, 0);
    expect_span(c + 1, c + 40, "post_light", SIG_LIGHT, 'hF, 0);
    tick(45);

    check("sb_left", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/occupancy_light_ctrl.md
Name: occupancy_light_ctrl

Overview:
Multi-zone successor to the single-zone movement/dark light gate. Per zone, it synchronises and debounces the movement sensor and runs a hold-timer FSM, so lights stay on for a programmable time after the last movement. A shared, debounced dark sensor gates only the turn-on. It sits between the raw sensor pins and the lighting driver stage.

Parameters:
- NUM_ZONES, 4, number of independent zones (≥1).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a sensor change (≥1).
- HOLD_CYCLES, 1000, cycles the light stays on after debounced movement falls (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- movement  input  NUM_ZONES  raw per-zone movement sensors; 1 = movement. Asynchronous to clk.
- dark  input  1  raw dark sensor; 1 = dark. Asynchronous to clk.
- auto_light  output  NUM_ZONES  registered per-zone light enable.
- timeout  output  NUM_ZONES  one-cycle pulse when a zone's hold timer expires.
- occupied_count  output  $clog2(NUM_ZONES+1)  registered count of zones in ON or HOLD.
- any_light  output  1  registered OR of all zones in ON or HOLD.

Behaviour:
- Reset:
  - Async assert, sync deassert handled upstream.
  - All synchroniser flops, debounced values, counters and timers clear to 0.
  - All FSMs go to OFF.
  - auto_light, timeout, occupied_count and any_light all read 0.
- Synchronisers: two-flop synchroniser on every movement bit and on dark.
- Debounce (per zone, and one for dark):
  - A counter runs while the synchronised value differs from the debounced value.
  - The debounced value flips when the counter reaches DEBOUNCE_CYCLES-1 while the difference persists.
  - Any cycle where the synchronised value equals the debounced value clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES are never seen.
- Zone FSM, states OFF / ON / HOLD:
  - OFF: auto_light=0. Go to ON when mov_db=1 and dark_db=1 in the same cycle. mov_db=1 with dark_db=0 stays OFF.
  - ON: auto_light=1. dark_db is ignored, so going bright never cuts an occupied zone. Go to HOLD when mov_db=0, loading timer = HOLD_CYCLES-1.
  - HOLD: auto_light=1.
    - mov_db=1: go to ON (retrigger; dark not checked).
    - Otherwise, timer==0: go to OFF and assert timeout[i] for that one transition cycle.
    - Otherwise: decrement the timer.
  - Retrigger and expiry in the same cycle: retrigger wins, no timeout pulse.
- Outputs:
  - auto_light is registered from the state.
  - Latency from first rising edge sampling movement=1 (held, dark_db already 1) to auto_light=1 is exactly DEBOUNCE_CYCLES+3 edges.
  - After mov_db falls, auto_light stays 1 for exactly HOLD_CYCLES cycles. It reads 0 on the cycle after timeout pulses.
- Timer: width $clog2(HOLD_CYCLES+1), unsigned. Never underflows; only decrements when nonzero.
- occupied_count and any_light are updated one cycle after the state, consistent with auto_light from the same cycle.
- Zones are fully independent. Simultaneous events in several zones are each handled in the same cycle.
- Reset mid-hold: the timer is discarded and the light goes off immediately.

Optional Feature:
- Macro: OCCUPANCY_MANUAL_OVERRIDE_EN.
- When defined:
  - Adds port force_on (input, NUM_ZONES).
  - Synchronised (two flops), not debounced.
  - While force_on[i]=1, zone i goes to and stays in ON regardless of dark and movement.
  - On release, the zone enters HOLD with a full reload. The normal timeout follows.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Setup for all scenarios: NUM_ZONES=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16.
- Reset release, all inputs 0 → all outputs 0 for 50 cycles.
- dark=1 held, movement[0] rises and holds → auto_light=4'b0001 exactly 7 edges later; occupied_count=1 one cycle after; other zones stay 0.
- Hold and retrigger:
  - movement[0] falls → light stays on 16 cycles, then timeout[0] pulses once and auto_light[0]=0.
  - Repeat, re-asserting movement at hold cycle 10 → no timeout, light stays on continuously.
- dark=0, movement[1]=1 held → auto_light[1] stays 0. Raising dark=1 → light on after dark debounce plus 3 edges. Dropping dark while occupied → light stays on.
- Glitch rejection: movement[2] 3-cycle pulses separated by 3-cycle gaps for 100 cycles → auto_light[2] never asserts.
- All four zones triggered together, then rst_n pulled low mid-HOLD → all outputs 0 asynchronously. After release, no timeout pulse.
